tl_error_slave_buffered: RTL and testbench

//  TileLink-UL/UH error slave with parametrised A- and D-channel buffering. It

---
 rtl/tl_error_slave_buffered.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_tl_error_slave_buffered.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_error_slave_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tl_error_slave_buffered
// Brief    : TileLink-UL/UH error slave; buffered A/D queues, denied responses.
//            Optional first-error log enabled by defining TL_ERR_LOG_EN.
// Revision : 1.0
// ============================================================================
module tl_error_slave_buffered #(
    parameter int ADDR_W   = 14,
    parameter int SRC_W    = 5,
    parameter int SIZE_W   = 4,
    parameter int DATA_W   = 32,
    parameter int A_DEPTH  = 2,
    parameter int D_DEPTH  = 2,
    parameter int MAX_LGSZ = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic [SRC_W-1:0]    a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                a_corrupt,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [SIZE_W-1:0]   d_size,
    output logic [SRC_W-1:0]    d_source,
    output logic                d_denied,
    output logic                d_corrupt,
    output logic [DATA_W-1:0]   d_data
`ifdef TL_ERR_LOG_EN
    ,
    output logic                log_valid,
    output logic [ADDR_W-1:0]   log_addr,
    output logic [SRC_W-1:0]    log_source,
    input  logic                log_clear
`endif
);

    localparam int BEAT_BYTES   = DATA_W / 8;
    localparam int LG_BB        = $clog2(BEAT_BYTES);
    localparam int MAX_BEATS_LG = (MAX_LGSZ > LG_BB) ? (MAX_LGSZ - LG_BB) : 0;
    localparam int BCNT_W       = MAX_BEATS_LG + 1;
    localparam int AP_W         = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
    localparam int AC_W         = $clog2(A_DEPTH) + 1;
    localparam int DP_W         = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
    localparam int DC_W         = $clog2(D_DEPTH) + 1;

    localparam logic [AC_W-1:0] A_FULL_CNT = AC_W'(A_DEPTH);
    localparam logic [AP_W-1:0] A_LAST     = AP_W'(A_DEPTH - 1);
    localparam logic [DC_W-1:0] D_FULL_CNT = DC_W'(D_DEPTH);
    localparam logic [DP_W-1:0] D_LAST     = DP_W'(D_DEPTH - 1);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_ARITH    = 3'd2;
    localparam logic [2:0] OP_LOGIC    = 3'd3;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_INTENT   = 3'd5;

    localparam logic [2:0] D_ACK       = 3'd0;
    localparam logic [2:0] D_ACK_DATA  = 3'd1;
    localparam logic [2:0] D_HINT_ACK  = 3'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Beats in a burst: sizes at or below one beat take one, larger sizes are clamped.
    function automatic logic [BCNT_W-1:0] f_beats(input logic [SIZE_W-1:0] sz);
        int lg;
        lg = int'(sz);
        if (lg > MAX_LGSZ) lg = MAX_LGSZ;
        if (lg <= LG_BB) return BCNT_W'(1);
        return BCNT_W'(1) << (lg - LG_BB);
    endfunction

    // ---------------- A queue ----------------
    logic [2:0]        a_op_mem   [A_DEPTH];
    logic [SIZE_W-1:0] a_size_mem [A_DEPTH];
    logic [SRC_W-1:0]  a_src_mem  [A_DEPTH];
    logic [AP_W-1:0]   a_wptr_q, a_rptr_q;
    logic [AC_W-1:0]   a_cnt_q;
    logic              rdy_q;
    logic              a_full, a_empty, a_push, a_pop;
    logic [2:0]        a_head_op;
    logic [SIZE_W-1:0] a_head_size;
    logic [SRC_W-1:0]  a_head_src;

    assign a_full      = (a_cnt_q == A_FULL_CNT);
    assign a_empty     = (a_cnt_q == '0);
    assign a_ready     = rdy_q & ~a_full;
    assign a_push      = a_valid & a_ready;
    assign a_head_op   = a_op_mem[a_rptr_q];
    assign a_head_size = a_size_mem[a_rptr_q];
    assign a_head_src  = a_src_mem[a_rptr_q];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q    <= 1'b0;
            a_wptr_q <= '0;
            a_rptr_q <= '0;
            a_cnt_q  <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (a_push) a_wptr_q <= (a_wptr_q == A_LAST) ? '0 : a_wptr_q + 1'b1;
            if (a_pop)  a_rptr_q <= (a_rptr_q == A_LAST) ? '0 : a_rptr_q + 1'b1;
            case ({a_push, a_pop})
                2'b10:   a_cnt_q <= a_cnt_q + 1'b1;
                2'b01:   a_cnt_q <= a_cnt_q - 1'b1;
                default: a_cnt_q <= a_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (a_push) begin
            a_op_mem[a_wptr_q]   <= a_opcode;
            a_size_mem[a_wptr_q] <= a_size;
            a_src_mem[a_wptr_q]  <= a_source;
        end
    end

    // ---------------- D queue ----------------
    logic [2:0]        d_op_mem   [D_DEPTH];
    logic [SIZE_W-1:0] d_size_mem [D_DEPTH];
    logic [SRC_W-1:0]  d_src_mem  [D_DEPTH];
    logic              d_cor_mem  [D_DEPTH];
    logic [DP_W-1:0]   d_wptr_q, d_rptr_q;
    logic [DC_W-1:0]   d_cnt_q;
    logic              d_full, d_empty, d_push, d_pop;

    assign d_full  = (d_cnt_q == D_FULL_CNT);
    assign d_empty = (d_cnt_q == '0);
    assign d_pop   = ~d_empty & d_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_wptr_q <= '0;
            d_rptr_q <= '0;
            d_cnt_q  <= '0;
        end else begin
            if (d_push) d_wptr_q <= (d_wptr_q == D_LAST) ? '0 : d_wptr_q + 1'b1;
            if (d_pop)  d_rptr_q <= (d_rptr_q == D_LAST) ? '0 : d_rptr_q + 1'b1;
            case ({d_push, d_pop})
                2'b10:   d_cnt_q <= d_cnt_q + 1'b1;
                2'b01:   d_cnt_q <= d_cnt_q - 1'b1;
                default: d_cnt_q <= d_cnt_q;
            endcase
        end
    end

    // ---------------- Response FSM ----------------
    logic [1:0]        state_q, state_d;
    logic [BCNT_W-1:0] beats_q, beats_d;
    logic [2:0]        rsp_op_q, rsp_op_d;
    logic              rsp_cor_q, rsp_cor_d;
    logic [SIZE_W-1:0] rsp_size_q, rsp_size_d;
    logic [SRC_W-1:0]  rsp_src_q, rsp_src_d;

    always_ff @(posedge clock) begin
        if (d_push) begin
            d_op_mem[d_wptr_q]   <= rsp_op_q;
            d_size_mem[d_wptr_q] <= rsp_size_q;
            d_src_mem[d_wptr_q]  <= rsp_src_q;
            d_cor_mem[d_wptr_q]  <= rsp_cor_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        rsp_op_d   = rsp_op_q;
        rsp_cor_d  = rsp_cor_q;
        rsp_size_d = rsp_size_q;
        rsp_src_d  = rsp_src_q;
        a_pop      = 1'b0;
        d_push     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!a_empty) begin
                    rsp_size_d = a_head_size;
                    rsp_src_d  = a_head_src;
                    // Puts keep their first beat queued; DRAIN consumes every beat.
                    if (a_head_op == OP_PUT_FULL || a_head_op == OP_PUT_PART) begin
                        beats_d   = f_beats(a_head_size);
                        rsp_op_d  = D_ACK;
                        rsp_cor_d = 1'b0;
                        state_d   = ST_DRAIN;
                    end else begin
                        a_pop   = 1'b1;
                        state_d = ST_RESP;
                        case (a_head_op)
                            OP_ARITH, OP_LOGIC, OP_GET: begin
                                beats_d   = f_beats(a_head_size);
                                rsp_op_d  = D_ACK_DATA;
                                rsp_cor_d = 1'b1;
                            end
                            OP_INTENT: begin
                                beats_d   = BCNT_W'(1);
                                rsp_op_d  = D_HINT_ACK;
                                rsp_cor_d = 1'b0;
                            end
                            default: begin
                                beats_d   = BCNT_W'(1);
                                rsp_op_d  = D_ACK;
                                rsp_cor_d = 1'b0;
                            end
                        endcase
                    end
                end
            end
            ST_DRAIN: begin
                if (!a_empty) begin
                    a_pop = 1'b1;
                    if (beats_q == BCNT_W'(1)) state_d = ST_ACK;
                    else                       beats_d = beats_q - 1'b1;
                end
            end
            ST_ACK: begin
                if (!d_full) begin
                    d_push  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (!d_full) begin
                    d_push = 1'b1;
                    if (beats_q == BCNT_W'(1)) state_d = ST_IDLE;
                    else                       beats_d = beats_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            beats_q    <= '0;
            rsp_op_q   <= '0;
            rsp_cor_q  <= 1'b0;
            rsp_size_q <= '0;
            rsp_src_q  <= '0;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            rsp_op_q   <= rsp_op_d;
            rsp_cor_q  <= rsp_cor_d;
            rsp_size_q <= rsp_size_d;
            rsp_src_q  <= rsp_src_d;
        end
    end

    assign d_valid   = ~d_empty;
    assign d_opcode  = d_op_mem[d_rptr_q];
    assign d_param   = 2'b00;
    assign d_size    = d_size_mem[d_rptr_q];
    assign d_source  = d_src_mem[d_rptr_q];
    assign d_denied  = d_valid;
    assign d_corrupt = d_valid & d_cor_mem[d_rptr_q];
    assign d_data    = '0;

`ifdef TL_ERR_LOG_EN
    // ---------------- First-error log ----------------
    logic [ADDR_W-1:0] a_addr_mem [A_DEPTH];
    logic              log_valid_q;
    logic [ADDR_W-1:0] log_addr_q;
    logic [SRC_W-1:0]  log_src_q;
    logic              log_cap;
    logic              unused_inputs;

    always_ff @(posedge clock) begin
        if (a_push) a_addr_mem[a_wptr_q] <= a_address;
    end

    assign log_cap = (state_q == ST_IDLE) & ~a_empty & ~log_valid_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            log_valid_q <= 1'b0;
            log_addr_q  <= '0;
            log_src_q   <= '0;
        end else if (log_cap) begin
            log_valid_q <= 1'b1;
            log_addr_q  <= a_addr_mem[a_rptr_q];
            log_src_q   <= a_head_src;
        end else if (log_clear) begin
            log_valid_q <= 1'b0;
        end
    end

    assign log_valid     = log_valid_q;
    assign log_addr      = log_addr_q;
    assign log_source    = log_src_q;
    assign unused_inputs = ^{a_param, a_mask, a_data, a_corrupt};
`else
    logic unused_inputs;
    assign unused_inputs = ^{a_param, a_mask, a_data, a_corrupt, a_address};
`endif

endmodule
`default_nettype wire

// File: tb/tb_tl_error_slave_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_error_slave_buffered
// Brief    : Directed self-checking bench for tl_error_slave_buffered.
// Revision : 1.0
// ============================================================================
module tb_tl_error_slave_buffered;

    localparam int ADDR_W = 14;
    localparam int SRC_W  = 5;
    localparam int SIZE_W = 4;
    localparam int DATA_W = 32;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                a_valid = 1'b0;
    logic                a_ready;
    logic [2:0]          a_opcode = '0;
    logic [2:0]          a_param = '0;
    logic [SIZE_W-1:0]   a_size = '0;
    logic [SRC_W-1:0]    a_source = '0;
    logic [ADDR_W-1:0]   a_address = '0;
    logic [DATA_W/8-1:0] a_mask = '1;
    logic [DATA_W-1:0]   a_data = '0;
    logic                a_corrupt = 1'b0;
    logic                d_valid;
    logic                d_ready = 1'b1;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    logic [SIZE_W-1:0]   d_size;
    logic [SRC_W-1:0]    d_source;
    logic                d_denied;
    logic                d_corrupt;
    logic [DATA_W-1:0]   d_data;
`ifdef TL_ERR_LOG_EN
    logic                log_valid;
    logic [ADDR_W-1:0]   log_addr;
    logic [SRC_W-1:0]    log_source;
    logic                log_clear = 1'b0;
`endif

    int compared   = 0;
    int mismatched = 0;
    logic saw_bp   = 1'b0;

    tl_error_slave_buffered dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .a_corrupt (a_corrupt),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_corrupt (d_corrupt),
        .d_data    (d_data)
`ifdef TL_ERR_LOG_EN
        ,
        .log_valid (log_valid),
        .log_addr  (log_addr),
        .log_source(log_source),
        .log_clear (log_clear)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one A beat and hold it until accepted; returns just after the fire edge.
    task automatic send(input string tag, input logic [2:0] op, input logic [3:0] sz,
                        input logic [4:0] src, input logic [13:0] addr);
        int n;
        n = 0;
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        while (!a_ready && n < 50) begin
            saw_bp = 1'b1;
            tick();
            n++;
        end
        chk({tag, ".accept"}, a_ready, 1);
        tick();
        a_valid = 1'b0;
    endtask

    // Wait for a response, check latency and every beat, then the beat count.
    task automatic expect_resp(input string tag, input logic [2:0] eop, input logic [3:0] esz,
                               input logic [4:0] esrc, input logic ecor, input int ebeats,
                               input int elat);
        int lat;
        int nb;
        lat = 0;
        nb  = 0;
        while (!d_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".data"}, d_data, 0);
        while (d_valid && nb < 40) begin
            chk($sformatf("%s.beat%0d", tag, nb),
                {d_opcode, d_param, d_size, d_source, d_denied, d_corrupt},
                {eop, 2'b00, esz, esrc, 1'b1, ecor});
            tick();
            nb++;
        end
        chk({tag, ".beats"}, nb, ebeats);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) tick();
        chk("rst.d_valid", d_valid, 0);
        chk("rst.a_ready", a_ready, 0);
        reset_n = 1'b1;
        chk("rst.a_ready_pre_clk", a_ready, 0);
        tick();
        chk("rst.a_ready_post_clk", a_ready, 1);
        chk("rst.d_valid_post", d_valid, 0);

        // 1: single-beat Get, 2-cycle latency
        send("t1", 3'd4, 4'd2, 5'd5, 14'h100);
        expect_resp("t1", 3'd1, 4'd2, 5'd5, 1'b1, 1, 2);

        // 2: 16-byte Get -> 4 beats; a following Intent proves the FSM is back in IDLE
        send("t2", 3'd4, 4'd4, 5'd7, 14'h040);
        expect_resp("t2", 3'd1, 4'd4, 5'd7, 1'b1, 4, 2);
        send("hint", 3'd5, 4'd2, 5'd6, 14'h044);
        expect_resp("hint", 3'd2, 4'd2, 5'd6, 1'b0, 1, 2);

        // Other opcode classes and size boundaries
        send("ill6", 3'd6, 4'd5, 5'd8, 14'h048);
        expect_resp("ill6", 3'd0, 4'd5, 5'd8, 1'b0, 1, 2);
        send("ill7", 3'd7, 4'd2, 5'd9, 14'h04C);
        expect_resp("ill7", 3'd0, 4'd2, 5'd9, 1'b0, 1, 2);
        send("arith", 3'd2, 4'd3, 5'd10, 14'h050);
        expect_resp("arith", 3'd1, 4'd3, 5'd10, 1'b1, 2, 2);
        send("logic", 3'd3, 4'd0, 5'd11, 14'h054);
        expect_resp("logic", 3'd1, 4'd0, 5'd11, 1'b1, 1, 2);
        send("clamp", 3'd4, 4'd9, 5'd12, 14'h058);
        expect_resp("clamp", 3'd1, 4'd9, 5'd12, 1'b1, 16, 2);

        // 3: PutFull of two beats -> one AccessAck after the last beat
        send("t3.b0", 3'd0, 4'd3, 5'd3, 14'h060);
        send("t3.b1", 3'd0, 4'd3, 5'd3, 14'h064);
        expect_resp("t3", 3'd0, 4'd3, 5'd3, 1'b0, 1, 3);
        repeat (4) tick();
        chk("t3.no_extra", d_valid, 0);
        send("ppart", 3'd1, 4'd1, 5'd4, 14'h068);
        expect_resp("ppart", 3'd0, 4'd1, 5'd4, 1'b0, 1, 3);

        // 4: back-pressure with d_ready low, then in-order drain
        d_ready = 1'b0;
        saw_bp  = 1'b0;
        send("t4.g1", 3'd4, 4'd2, 5'd1, 14'h070);
        send("t4.g2", 3'd4, 4'd2, 5'd2, 14'h074);
        send("t4.g3", 3'd4, 4'd2, 5'd3, 14'h078);
        send("t4.g4", 3'd4, 4'd2, 5'd4, 14'h07C);
        chk("t4.backpressure", saw_bp, 1);
        repeat (4) tick();
        chk("t4.hold_valid", d_valid, 1);
        chk("t4.hold_src", d_source, 1);
        repeat (2) tick();
        chk("t4.stable", {d_valid, d_opcode, d_source}, {1'b1, 3'd1, 5'd1});
        d_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!d_valid && n < 40) begin
                tick();
                n++;
            end
            chk($sformatf("t4.resp%0d", i), {d_valid, d_opcode, d_source},
                {1'b1, 3'd1, 5'(i + 1)});
            tick();
        end
        repeat (3) tick();
        chk("t4.drained", d_valid, 0);

        // 5: reset mid-burst
        send("t5", 3'd4, 4'd4, 5'd9, 14'h080);
        tick();
        tick();
        chk("t5.first_beat", d_valid, 1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("t5.d_valid_async", d_valid, 0);
        chk("t5.a_ready_rst", a_ready, 0);
        tick();
        reset_n = 1'b1;
        chk("t5.a_ready_release", a_ready, 0);
        tick();
        chk("t5.a_ready_after", a_ready, 1);
        repeat (3) tick();
        chk("t5.no_replay", d_valid, 0);
        send("t5.post", 3'd4, 4'd2, 5'd2, 14'h084);
        expect_resp("t5.post", 3'd1, 4'd2, 5'd2, 1'b1, 1, 2);

`ifdef TL_ERR_LOG_EN
        // 6: first-error log, clear, recapture (log was reset in test 5 but has
        // since captured t5.post, so clear it first)
        log_clear = 1'b1;
        tick();
        log_clear = 1'b0;
        chk("t6.cleared0", log_valid, 0);
        send("t6.g1", 3'd4, 4'd2, 5'd11, 14'h2A0);
        expect_resp("t6.g1", 3'd1, 4'd2, 5'd11, 1'b1, 1, 2);
        send("t6.g2", 3'd4, 4'd2, 5'd12, 14'h3F0);
        expect_resp("t6.g2", 3'd1, 4'd2, 5'd12, 1'b1, 1, 2);
        chk("t6.log_valid", log_valid, 1);
        chk("t6.log_addr", log_addr, 14'h2A0);
        chk("t6.log_source", log_source, 11);
        log_clear = 1'b1;
        tick();
        log_clear = 1'b0;
        chk("t6.cleared", log_valid, 0);
        send("t6.g3", 3'd4, 4'd2, 5'd13, 14'h155);
        expect_resp("t6.g3", 3'd1, 4'd2, 5'd13, 1'b1, 1, 2);
        chk("t6.recap_valid", log_valid, 1);
        chk("t6.recap_addr", log_addr, 14'h155);
        chk("t6.recap_source", log_source, 13);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
